// File: rtl/baud_pkg.sv
// Shared defaults and 50 MHz / OVS=16 divisor presets for the UART baud tick generator.
package baud_pkg;

  localparam int BAUD_CNT_W  = 16;
  localparam int BAUD_FRAC_W = 4;
  localparam int BAUD_OVS    = 16;

  typedef struct packed {
    logic [BAUD_CNT_W-1:0]  div_int;
    logic [BAUD_FRAC_W-1:0] div_frac;
  } baud_div_t;

  // Oversample period = div_int + 1 + div_frac/16 cycles of a 50 MHz clock.
  localparam baud_div_t B9600   = '{div_int: 16'd324, div_frac: 4'd8};
  localparam baud_div_t B38400  = '{div_int: 16'd80,  div_frac: 4'd6};
  localparam baud_div_t B57600  = '{div_int: 16'd53,  div_frac: 4'd4};
  localparam baud_div_t B115200 = '{div_int: 16'd26,  div_frac: 4'd2};

endpackage

// File: rtl/frac_divider.sv
// Fractional period counter: raises a raw strobe once per (act_int + 1 + carry) cycles,
// where carry is the overflow of the fractional accumulator for the current period.
module frac_divider #(
  parameter int CNT_W  = 16,
  parameter int FRAC_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              sync_i,
  input  logic [CNT_W-1:0]  act_int_i,
  input  logic [FRAC_W-1:0] act_frac_i,
  output logic              strobe_o
);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic [FRAC_W:0]   acc_sum;
  logic [CNT_W:0]    term_wide;
  logic [CNT_W-1:0]  terminal;

  // Terminal saturates so the counter never wraps past its own width.
  always_comb begin
    acc_sum   = {1'b0, acc_q} + {1'b0, act_frac_i};
    term_wide = {1'b0, act_int_i} + {{CNT_W{1'b0}}, acc_sum[FRAC_W]};
    terminal  = term_wide[CNT_W] ? {CNT_W{1'b1}} : term_wide[CNT_W-1:0];
    strobe_o  = enable_i && !sync_i && (cnt_q == terminal);
  end

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    acc_d = acc_q;
    if (!enable_i || sync_i) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (strobe_o) begin
      cnt_d = '0;
      acc_d = acc_sum[FRAC_W-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/baud_tick_gen.sv
// Baud tick generator: shadow/active divisor handoff, oversample counter and
// registered tick_ovs / tick_bit / tick_mid pulses for the UART shift FSMs.
module baud_tick_gen
  import baud_pkg::*;
#(
  parameter int CNT_W  = BAUD_CNT_W,
  parameter int FRAC_W = BAUD_FRAC_W,
  parameter int OVS    = BAUD_OVS
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic              sync,
  input  logic              load,
  input  logic [CNT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  output logic              tick_ovs,
  output logic              tick_bit,
  output logic              tick_mid,
  output logic              pending
);

  localparam int                OCNT_W      = $clog2(OVS);
  localparam logic [OCNT_W-1:0] OCNT_LAST   = OCNT_W'(OVS - 1);
  localparam logic [OCNT_W-1:0] OCNT_PREMID = OCNT_W'(OVS / 2 - 1);

  logic [CNT_W-1:0]  sh_int_q, sh_int_d, act_int_q, act_int_d;
  logic [FRAC_W-1:0] sh_frac_q, sh_frac_d, act_frac_q, act_frac_d;
  logic              pending_q, pending_d;
  logic [OCNT_W-1:0] ocnt_q, ocnt_d;
  logic              tick_ovs_q, tick_ovs_d;
  logic              tick_bit_q, tick_bit_d;
  logic              tick_mid_q, tick_mid_d;
  logic              ovs_strobe;
  logic              copy;

  frac_divider #(
    .CNT_W (CNT_W),
    .FRAC_W(FRAC_W)
  ) u_frac_divider (
    .clk       (clk),
    .reset     (reset),
    .enable_i  (enable),
    .sync_i    (sync),
    .act_int_i (act_int_q),
    .act_frac_i(act_frac_q),
    .strobe_o  (ovs_strobe)
  );

  // The copy takes the old shadow, so a load landing on the copy edge stays pending.
  always_comb begin
    copy       = pending_q && (ovs_strobe || !enable);
    sh_int_d   = load ? div_int : sh_int_q;
    sh_frac_d  = load ? div_frac : sh_frac_q;
    act_int_d  = copy ? sh_int_q : act_int_q;
    act_frac_d = copy ? sh_frac_q : act_frac_q;
    pending_d  = load ? 1'b1 : (copy ? 1'b0 : pending_q);
  end

  always_comb begin
    ocnt_d     = ocnt_q;
    tick_ovs_d = ovs_strobe;
    tick_bit_d = ovs_strobe && (ocnt_q == OCNT_LAST);
    tick_mid_d = ovs_strobe && (ocnt_q == OCNT_PREMID);
    if (!enable || sync) begin
      ocnt_d = '0;
    end else if (ovs_strobe) begin
      ocnt_d = ocnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sh_int_q   <= '0;
      sh_frac_q  <= '0;
      act_int_q  <= '0;
      act_frac_q <= '0;
      pending_q  <= 1'b0;
      ocnt_q     <= '0;
      tick_ovs_q <= 1'b0;
      tick_bit_q <= 1'b0;
      tick_mid_q <= 1'b0;
    end else begin
      sh_int_q   <= sh_int_d;
      sh_frac_q  <= sh_frac_d;
      act_int_q  <= act_int_d;
      act_frac_q <= act_frac_d;
      pending_q  <= pending_d;
      ocnt_q     <= ocnt_d;
      tick_ovs_q <= tick_ovs_d;
      tick_bit_q <= tick_bit_d;
      tick_mid_q <= tick_mid_d;
    end
  end

  assign tick_ovs = tick_ovs_q;
  assign tick_bit = tick_bit_q;
  assign tick_mid = tick_mid_q;
  assign pending  = pending_q;

endmodule
